data_mem_sequencer: RTL and testbench

Controller that sequences byte, halfword, word and doubleword accesses onto the single byte-wide port of the data RAM (256 x 8, big-endian byte order). It accepts one request at a time from the pipeline MEM stage through a valid/ready handshake. It issues one RAM byte access per cycle, assembles read data most-significant byte first, and returns a single completion response. It sits between the MEM stage and the data RAM and is the only master of the RAM port.

---
 rtl/data_mem_sequencer.sv | 148 ++++++++++++++
 tb/tb_data_mem_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_sequencer.sv
// Sequences byte/half/word/dword requests onto a byte-wide big-endian data RAM,
// one RAM byte per cycle, MSB first, with a single registered completion pulse.
module data_mem_sequencer #(
  parameter int MEM_DEPTH = 256,
  parameter int MEM_AW    = $clog2(MEM_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_rw,
  input  logic [1:0]        i_req_mode,
  input  logic [31:0]       i_req_addr,
  input  logic [63:0]       i_req_wdata,
  output logic              o_rsp_valid,
  output logic              o_rsp_err,
  output logic [63:0]       o_rsp_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [MEM_AW-1:0] o_mem_addr,
  output logic [7:0]        o_mem_wbyte,
  input  logic [7:0]        i_mem_rbyte
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  typedef struct packed {
    logic              rw;
    logic [1:0]        mode;
    logic [MEM_AW-1:0] addr;
    logic [63:0]       wdata;
  } req_t;

  state_t      r_state, w_state_nxt;
  req_t        r_req;
  logic [2:0]  r_cnt;
  logic [55:0] r_acc;
  logic        r_rsp_valid, r_rsp_err;
  logic [63:0] r_rsp_rdata;

  logic        w_misalign;
  logic [2:0]  w_last;
  logic [2:0]  w_bidx;
  logic [63:0] w_acc_nxt;
  logic        w_unused_addr;

  // Address bits above the RAM width are deliberately dropped.
  assign w_unused_addr = ^i_req_addr[31:MEM_AW];

  always_comb begin
    w_misalign = 1'b0;
    case (i_req_mode)
      2'b01:   w_misalign = i_req_addr[0];
      2'b10:   w_misalign = |i_req_addr[1:0];
      2'b11:   w_misalign = |i_req_addr[2:0];
      default: w_misalign = 1'b0;
    endcase
  end

  always_comb begin
    w_last = 3'd0;
    case (r_req.mode)
      2'b01:   w_last = 3'd1;
      2'b10:   w_last = 3'd3;
      2'b11:   w_last = 3'd7;
      default: w_last = 3'd0;
    endcase
  end

  assign w_bidx    = w_last - r_cnt;
  assign w_acc_nxt = {r_acc, i_mem_rbyte};

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // RAM strobes are masked during reset so an aborted access stops at the reset edge.
  always_comb begin
    w_state_nxt = r_state;
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wbyte = '0;
    case (r_state)
      S_IDLE: begin
        if (i_req_valid) w_state_nxt = w_misalign ? S_RESP : S_ACCESS;
      end
      S_ACCESS: begin
        o_mem_en    = ~i_reset;
        o_mem_we    = r_req.rw & ~i_reset;
        o_mem_addr  = r_req.addr + MEM_AW'(r_cnt);
        o_mem_wbyte = r_req.wdata[{w_bidx, 3'b000} +: 8];
        if (r_cnt == w_last) w_state_nxt = S_RESP;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_req       <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_req.rw    <= i_req_rw;
            r_req.mode  <= i_req_mode;
            r_req.addr  <= i_req_addr[MEM_AW-1:0];
            r_req.wdata <= i_req_wdata;
            r_cnt       <= '0;
            r_acc       <= '0;
            if (w_misalign) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end
          end
        end
        S_ACCESS: begin
          if (!r_req.rw) r_acc <= w_acc_nxt[55:0];
          if (r_cnt == w_last) begin
            r_cnt       <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_req.rw ? 64'd0 : w_acc_nxt;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_req_ready = (r_state == S_IDLE) & ~i_reset;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_err   = r_rsp_err;
  assign o_rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_data_mem_sequencer.sv
// Bench for data_mem_sequencer: byte RAM model on the port, transaction-level
// reference memory, directed scenarios plus randomized requests.
module tb_data_mem_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_rw;
  logic [1:0]  req_mode;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [63:0] rsp_rdata;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr, mem_wbyte, mem_rbyte;

  logic [7:0] ram [256];
  logic [7:0] ref_mem [256];
  int q_addr[$];
  int q_byte[$];
  int q_we[$];
  int pass = 0;
  int total = 0;

  always #5 clk = ~clk;

  data_mem_sequencer #(.MEM_DEPTH(256), .MEM_AW(8)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_rw(req_rw),
    .i_req_mode(req_mode), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .o_rsp_err(rsp_err), .o_rsp_rdata(rsp_rdata),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wbyte(mem_wbyte), .i_mem_rbyte(mem_rbyte)
  );

  assign mem_rbyte = ram[mem_addr];
  always @(posedge clk) if (mem_en && mem_we) ram[mem_addr] <= mem_wbyte;

  // Reference: an access of N bytes touches addr..addr+N-1 (mod 256), MSB at addr.
  task automatic ref_access(input logic rw, input logic [1:0] mode, input logic [31:0] addr,
                            input logic [63:0] wd, output logic [63:0] rd, output logic err);
    int n;
    logic [63:0] t;
    n = 1 << mode;
    err = (addr % n) != 0;
    rd = 64'd0;
    if (err) return;
    for (int i = 0; i < n; i++) begin
      int a;
      a = int'((addr + 32'(i)) % 256);
      if (rw) begin
        t = wd >> (8 * (n - 1 - i));
        ref_mem[a] = t[7:0];
      end else begin
        rd = (rd << 8) | 64'(ref_mem[a]);
      end
    end
  endtask

  // Issues one request, scrambles inputs after acceptance, returns latency and RAM traffic.
  task automatic do_req(input logic rw, input logic [1:0] mode, input logic [31:0] addr,
                        input logic [63:0] wd, output logic [63:0] rd, output logic err,
                        output int lat);
    int guard;
    q_addr.delete(); q_byte.delete(); q_we.delete();
    @(negedge clk);
    req_valid = 1'b1; req_rw = rw; req_mode = mode; req_addr = addr; req_wdata = wd;
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    req_valid = 1'b0; req_rw = 1'($urandom); req_mode = 2'($urandom);
    req_addr = $urandom; req_wdata = {$urandom, $urandom};
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      if (mem_en) begin
        q_addr.push_back(int'(mem_addr)); q_byte.push_back(int'(mem_wbyte));
        q_we.push_back(int'(mem_we));
      end
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata;
    err = rsp_err;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (req_ready !== 1'b0) $display("FAIL rst_ready_in_reset got %b exp 0", req_ready); else pass++;
    total++; if (mem_en !== 1'b0) $display("FAIL rst_mem_en_in_reset got %b exp 0", mem_en); else pass++;
    reset = 1'b0;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", req_ready); else pass++;
    total++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 64'd0)
      $display("FAIL rst_rsp got v=%b e=%b d=%h exp 0/0/0", rsp_valid, rsp_err, rsp_rdata); else pass++;
    total++; if (mem_en !== 0 || mem_we !== 0 || mem_addr !== 0 || mem_wbyte !== 0)
      $display("FAIL rst_mem got en=%b we=%b a=%h b=%h exp all 0", mem_en, mem_we, mem_addr, mem_wbyte); else pass++;
  endtask

  task automatic test_word();
    logic [63:0] rd, erd, t;
    logic err, eerr;
    int lat;
    ref_access(1'b1, 2'b10, 32'h08, 64'hAABBCCDD, erd, eerr);
    do_req(1'b1, 2'b10, 32'h08, 64'hAABBCCDD, rd, err, lat);
    total++; if (lat !== 5) $display("FAIL word_wr_lat got %0d exp 5", lat); else pass++;
    total++; if (rd !== 64'd0 || err !== 1'b0) $display("FAIL word_wr_rsp got d=%h e=%b exp 0/0", rd, err); else pass++;
    for (int i = 0; i < 4; i++) begin
      int a, b, w;
      a = (i < q_addr.size()) ? q_addr[i] : -1;
      b = (i < q_byte.size()) ? q_byte[i] : -1;
      w = (i < q_we.size()) ? q_we[i] : -1;
      t = 64'hAABBCCDD >> (8 * (3 - i));
      total++; if (a !== 8 + i || b !== int'(t[7:0]) || w !== 1)
        $display("FAIL word_wr_op%0d got a=%h b=%h we=%0d exp a=%h b=%h we=1", i, a, b, w, 8 + i, t[7:0]); else pass++;
    end
    total++; if (q_addr.size() !== 4) $display("FAIL word_wr_nops got %0d exp 4", q_addr.size()); else pass++;
    ref_access(1'b0, 2'b10, 32'h08, 64'd0, erd, eerr);
    do_req(1'b0, 2'b10, 32'h08, 64'hFFFF_FFFF_FFFF_FFFF, rd, err, lat);
    total++; if (rd !== erd || erd !== 64'hAABBCCDD) $display("FAIL word_rd_data got %h exp %h", rd, erd); else pass++;
    total++; if (err !== 1'b0 || lat !== 5) $display("FAIL word_rd_rsp got e=%b lat=%0d exp 0/5", err, lat); else pass++;
  endtask

  task automatic test_short_reads();
    logic [63:0] rd, erd;
    logic err, eerr;
    int lat;
    ref_access(1'b0, 2'b00, 32'h0A, 64'd0, erd, eerr);
    do_req(1'b0, 2'b00, 32'h0A, 64'd0, rd, err, lat);
    total++; if (rd !== erd || lat !== 2) $display("FAIL byte_rd got %h lat=%0d exp %h lat=2", rd, lat, erd); else pass++;
    ref_access(1'b0, 2'b01, 32'h0A, 64'd0, erd, eerr);
    do_req(1'b0, 2'b01, 32'h0A, 64'd0, rd, err, lat);
    total++; if (rd !== erd || lat !== 3) $display("FAIL half_rd got %h lat=%0d exp %h lat=3", rd, lat, erd); else pass++;
  endtask

  task automatic test_dword_wrap();
    logic [63:0] rd, erd;
    logic err, eerr;
    int lat, bad;
    ref_access(1'b1, 2'b11, 32'hF8, 64'h0123456789ABCDEF, erd, eerr);
    do_req(1'b1, 2'b11, 32'hF8, 64'h0123456789ABCDEF, rd, err, lat);
    bad = (q_addr.size() != 8) ? 1 : 0;
    for (int i = 0; i < q_addr.size(); i++) if (q_addr[i] != 'hF8 + i) bad++;
    total++; if (bad !== 0) $display("FAIL dword_wr_addrs got %0d ops %0d bad exp 8 ops 0 bad", q_addr.size(), bad); else pass++;
    ref_access(1'b0, 2'b11, 32'h1F8, 64'd0, erd, eerr);
    do_req(1'b0, 2'b11, 32'h1F8, 64'd0, rd, err, lat);
    total++; if (rd !== erd) $display("FAIL dword_rd_data got %h exp %h", rd, erd); else pass++;
    total++; if (lat !== 9) $display("FAIL dword_rd_lat got %0d exp 9", lat); else pass++;
  endtask

  task automatic test_misaligned();
    logic [63:0] rd, erd;
    logic err, eerr;
    int lat;
    ref_access(1'b0, 2'b01, 32'h03, 64'd0, erd, eerr);
    do_req(1'b0, 2'b01, 32'h03, 64'd0, rd, err, lat);
    total++; if (err !== 1'b1 || rd !== 64'd0 || lat !== 1)
      $display("FAIL mis_half got e=%b d=%h lat=%0d exp 1/0/1", err, rd, lat); else pass++;
    total++; if (q_addr.size() !== 0) $display("FAIL mis_half_mem_en got %0d ops exp 0", q_addr.size()); else pass++;
    ref_access(1'b1, 2'b10, 32'h06, 64'h55667788, erd, eerr);
    do_req(1'b1, 2'b10, 32'h06, 64'h55667788, rd, err, lat);
    total++; if (err !== 1'b1 || lat !== 1 || q_addr.size() !== 0)
      $display("FAIL mis_word got e=%b lat=%0d ops=%0d exp 1/1/0", err, lat, q_addr.size()); else pass++;
    total++; if ({ram[6], ram[7], ram[8], ram[9]} !== {ref_mem[6], ref_mem[7], ref_mem[8], ref_mem[9]})
      $display("FAIL mis_word_ram got %h%h%h%h exp %h%h%h%h", ram[6], ram[7], ram[8], ram[9],
               ref_mem[6], ref_mem[7], ref_mem[8], ref_mem[9]); else pass++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] old22, old23;
    int guard, seen;
    old22 = ref_mem['h22]; old23 = ref_mem['h23];
    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b1; req_mode = 2'b10; req_addr = 32'h20; req_wdata = 64'h11223344;
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    req_valid = 1'b0;
    seen = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    if (rsp_valid) seen++;
    reset = 1'b0;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) $display("FAIL rmid_ready got %b exp 1", req_ready); else pass++;
    for (int k = 0; k < 10; k++) begin if (rsp_valid) seen++; @(negedge clk); end
    total++; if (seen !== 0) $display("FAIL rmid_no_rsp got %0d pulses exp 0", seen); else pass++;
    total++; if (ram['h20] !== 8'h11 || ram['h21] !== 8'h22)
      $display("FAIL rmid_written got %h %h exp 11 22", ram['h20], ram['h21]); else pass++;
    total++; if (ram['h22] !== old22 || ram['h23] !== old23)
      $display("FAIL rmid_untouched got %h %h exp %h %h", ram['h22], ram['h23], old22, old23); else pass++;
    ref_mem['h20] = 8'h11; ref_mem['h21] = 8'h22;
  endtask

  task automatic test_back_to_back();
    logic [63:0] e1, e2;
    logic eerr;
    int rk[$];
    logic [63:0] rdat[$];
    logic rdy1, rdy3;
    int guard;
    ref_access(1'b0, 2'b00, 32'h08, 64'd0, e1, eerr);
    ref_access(1'b0, 2'b00, 32'h09, 64'd0, e2, eerr);
    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b0; req_mode = 2'b00; req_addr = 32'h08; req_wdata = 64'd0;
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    rdy1 = 1'b1; rdy3 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (rsp_valid) begin rk.push_back(k); rdat.push_back(rsp_rdata); end
      if (k == 1) begin rdy1 = req_ready; req_addr = 32'h09; end
      if (k == 3) rdy3 = req_ready;
      if (k == 4) req_valid = 1'b0;
    end
    total++; if (rdy1 !== 1'b0 || rdy3 !== 1'b1) $display("FAIL b2b_ready got k1=%b k3=%b exp 0 1", rdy1, rdy3); else pass++;
    total++; if (rk.size() !== 2) $display("FAIL b2b_nrsp got %0d exp 2", rk.size());
    else if (rk[0] !== 2 || rk[1] !== 5) $display("FAIL b2b_timing got %0d,%0d exp 2,5", rk[0], rk[1]);
    else if (rdat[0] !== e1 || rdat[1] !== e2) $display("FAIL b2b_data got %h,%h exp %h,%h", rdat[0], rdat[1], e1, e2);
    else pass++;
  endtask

  task automatic test_random();
    logic [63:0] rd, erd, wd;
    logic err, eerr, rw;
    logic [1:0] mode;
    logic [31:0] addr;
    int lat, nb, en;
    for (int t = 0; t < 40; t++) begin
      rw = 1'($urandom); mode = 2'($urandom); addr = $urandom; wd = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) addr = addr & ~(32'((1 << mode) - 1));
      ref_access(rw, mode, addr, wd, erd, eerr);
      do_req(rw, mode, addr, wd, rd, err, lat);
      en = eerr ? 1 : (1 << mode) + 1;
      nb = eerr ? 0 : (1 << mode);
      total++; if (rd !== erd || err !== eerr)
        $display("FAIL rnd%0d_rsp got d=%h e=%b exp d=%h e=%b", t, rd, err, erd, eerr); else pass++;
      total++; if (lat !== en || q_addr.size() !== nb)
        $display("FAIL rnd%0d_timing got lat=%0d ops=%0d exp lat=%0d ops=%0d", t, lat, q_addr.size(), en, nb); else pass++;
    end
    nb = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) nb++;
    total++; if (nb !== 0) $display("FAIL ram_final got %0d differing bytes exp 0", nb); else pass++;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_mode = 2'b00;
    req_addr = 32'd0; req_wdata = 64'd0;
    for (int i = 0; i < 256; i++) begin ram[i] = 8'($urandom); ref_mem[i] = ram[i]; end
    test_reset();
    test_word();
    test_short_reads();
    test_dword_wrap();
    test_misaligned();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
